// File: rtl/rs_encoder.sv
// Systematic RS(204,188) byte-serial encoder over GF(2^8), poly 0x11D, t=8.
// Forwards the 188 message bytes, then emits 16 parity bytes from the LFSR.
module rs_encoder (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] In_Data,
    input  logic       In_Valid,
    input  logic       In_Sop,
    output logic       In_Ready,
    output logic [7:0] Out_Data,
    output logic       Out_Valid,
    output logic       Out_Sop,
    output logic       Out_Eop
);

    localparam int K    = 188;
    localparam int N    = 204;
    localparam int NPAR = N - K;

    // g(x) = prod_{i=0..15} (x + alpha^i); element [i] is the coefficient of x^i.
    localparam logic [NPAR-1:0][7:0] GEN = {
        8'd59,  8'd13,  8'd104, 8'd189, 8'd68,  8'd209, 8'd30,  8'd8,
        8'd163, 8'd65,  8'd41,  8'd229, 8'd98,  8'd50,  8'd36,  8'd59
    };

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [3:0] pcnt, pcnt_n;
    logic [7:0] r   [NPAR];
    logic [7:0] r_n [NPAR];
    logic [7:0] data_n;
    logic       valid_n, sop_n, eop_n;
    logic       accept, restart;
    logic [7:0] fb;

    // With a constant first operand this collapses to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    assign In_Ready = (state != PARITY);
    assign accept   = In_Valid && In_Ready;
    assign restart  = accept && In_Sop;
    // A start-of-packet byte sees an all-zero register, so no explicit clear cycle is needed.
    assign fb       = In_Data ^ (restart ? 8'h00 : r[NPAR-1]);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pcnt_n  = pcnt;
        for (int i = 0; i < NPAR; i++) r_n[i] = r[i];
        data_n  = Out_Data;
        valid_n = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        case (state)
            IDLE, DATA: begin
                if (accept && (restart || state == DATA)) begin
                    data_n  = In_Data;
                    valid_n = 1'b1;
                    sop_n   = restart;
                    r_n[0]  = gf_mul(GEN[0], fb);
                    for (int i = 1; i < NPAR; i++)
                        r_n[i] = (restart ? 8'h00 : r[i-1]) ^ gf_mul(GEN[i], fb);
                    if (restart) begin
                        state_n = DATA;
                        cnt_n   = 8'd1;
                    end else if (cnt == 8'(K - 1)) begin
                        state_n = PARITY;
                        cnt_n   = 8'd0;
                        pcnt_n  = 4'd0;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            PARITY: begin
                data_n  = r[NPAR-1];
                valid_n = 1'b1;
                eop_n   = (pcnt == 4'(NPAR - 1));
                r_n[0]  = 8'h00;
                for (int i = 1; i < NPAR; i++) r_n[i] = r[i-1];
                if (pcnt == 4'(NPAR - 1)) begin
                    state_n = IDLE;
                    pcnt_n  = 4'd0;
                end else begin
                    pcnt_n = pcnt + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            pcnt      <= 4'd0;
            for (int i = 0; i < NPAR; i++) r[i] <= 8'h00;
            Out_Data  <= 8'h00;
            Out_Valid <= 1'b0;
            Out_Sop   <= 1'b0;
            Out_Eop   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pcnt      <= pcnt_n;
            for (int i = 0; i < NPAR; i++) r[i] <= r_n[i];
            Out_Data  <= data_n;
            Out_Valid <= valid_n;
            Out_Sop   <= sop_n;
            Out_Eop   <= eop_n;
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// Self-checking bench for rs_encoder: polynomial-division reference model,
// expected-output queue, and syndrome evaluation of every completed codeword.
module tb_rs_encoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] In_Data;
  logic       In_Valid;
  logic       In_Sop;
  logic       In_Ready;
  logic [7:0] Out_Data;
  logic       Out_Valid;
  logic       Out_Sop;
  logic       Out_Eop;

  rs_encoder dut (
    .Clk(Clk), .Reset(Reset),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Sop(In_Sop), .In_Ready(In_Ready),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Sop(Out_Sop), .Out_Eop(Out_Eop)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [9:0] exp_q[$];          // {sop, eop, data}
  logic [7:0] gen [17];          // gen[k] = coefficient of x^k
  logic [7:0] msg [188];
  int         m_cnt = 0;
  bit         m_in_pkt = 0;
  logic [7:0] cw [204];
  int         cw_idx = 0;
  int         cyc = 0, sop_cyc = 0, eop_cyc = 0, eop_cnt = 0, rdy_low_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- GF(2^8) reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = (x[7]) ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gpow(input int e);
    logic [7:0] p = 8'h01;
    for (int i = 0; i < e; i++) p = gmul(p, 8'h02);
    return p;
  endfunction

  function automatic void build_gen();
    logic [7:0] root;
    for (int k = 0; k < 17; k++) gen[k] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      root = gpow(i);
      for (int k = 16; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(root, gen[k]);
      gen[0] = gmul(root, gen[0]);
    end
  endfunction

  // Long division of msg(x)*x^16 by g(x); c[i] holds the coefficient of x^(203-i).
  function automatic void push_parity();
    logic [7:0] c [204];
    logic [7:0] coef;
    for (int i = 0; i < 204; i++) c[i] = (i < 188) ? msg[i] : 8'h00;
    for (int i = 0; i < 188; i++) begin
      coef = c[i];
      for (int j = 1; j <= 16; j++) c[i+j] ^= gmul(coef, gen[16-j]);
    end
    for (int j = 0; j < 16; j++) exp_q.push_back({1'b0, (j == 15), c[188+j]});
  endfunction

  function automatic void model_accept(input logic [7:0] d, input bit sop);
    if (sop) begin
      m_in_pkt = 1;
      m_cnt    = 0;
    end
    if (!m_in_pkt) return;
    msg[m_cnt] = d;
    exp_q.push_back({sop, 1'b0, d});
    m_cnt++;
    if (m_cnt == 188) begin
      push_parity();
      m_in_pkt = 0;
    end
  endfunction

  function automatic logic [7:0] syndrome_or();
    logic [7:0] acc = 8'h00;
    logic [7:0] a, s;
    for (int i = 0; i < 16; i++) begin
      a = gpow(i);
      s = 8'h00;
      for (int k = 0; k < 204; k++) s = gmul(s, a) ^ cw[k];
      acc |= s;
    end
    return acc;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge Clk) begin
    logic [9:0] e;
    cyc++;
    if (!In_Ready) rdy_low_cnt++;
    if (Reset && Out_Valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {Out_Sop, Out_Eop, Out_Data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("out", {Out_Sop, Out_Eop, Out_Data}, e);
      end
      if (Out_Sop) begin
        cw_idx  = 0;
        sop_cyc = cyc;
      end
      if (cw_idx < 204) cw[cw_idx] = Out_Data;
      cw_idx++;
      if (Out_Eop) begin
        eop_cnt++;
        eop_cyc = cyc;
        check("cw_len", cw_idx, 204);
        if (cw_idx == 204) check("syndrome", syndrome_or(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d, input bit sop);
    int w = 0;
    @(negedge Clk);
    In_Valid = 1'b1;
    In_Data  = d;
    In_Sop   = sop;
    while (!In_Ready && w < 64) begin
      @(negedge Clk);
      w++;
    end
    if (!In_Ready) check("ready_timeout", 0, 1);
    else model_accept(d, sop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      In_Valid = 1'b0;
      In_Sop   = 1'b0;
    end
  endtask

  // mode 0: all zero, 1: impulse at byte 187, 2: random
  task automatic send_packet(input int len, input int mode, input bit gaps);
    logic [7:0] d;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      case (mode)
        0:       d = 8'h00;
        1:       d = (i == 187) ? 8'h01 : 8'h00;
        default: d = 8'($urandom_range(0, 255));
      endcase
      send(d, (i == 0));
    end
  endtask

  task automatic drain();
    int w = 0;
    idle(1);
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge Clk);
      w++;
    end
    idle(4);
    check("drain", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int eop_before;
    logic [7:0] sum;
    Reset    = 1'b0;
    In_Data  = 8'h00;
    In_Valid = 1'b0;
    In_Sop   = 1'b0;
    build_gen();
    #1;
    check("rst_valid", Out_Valid, 0);
    check("rst_data", Out_Data, 0);
    check("rst_ready", In_Ready, 1);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    idle(2);

    // all-zero packet, continuous
    rdy_low_cnt = 0;
    send_packet(188, 0, 0);
    drain();
    check("zero_span", eop_cyc - sop_cyc + 1, 204);
    check("zero_ready_low", rdy_low_cnt, 16);

    // impulse: parity equals generator coefficients
    send_packet(188, 1, 0);
    drain();
    for (int j = 0; j < 16; j++) check($sformatf("impulse_p%0d", j), cw[188+j], gen[15-j]);
    check("impulse_p15_alpha120", cw[203], gpow(120));
    sum = 8'h00;
    for (int i = 0; i < 16; i++) sum ^= gpow(i);
    check("impulse_p0_sum", cw[188], sum);

    // stray byte in IDLE is dropped
    send(8'hAB, 0);
    idle(3);
    send_packet(188, 1, 0);
    drain();
    check("after_stray_p15", cw[203], gpow(120));

    // random packets with gaps, back-to-back
    for (int p = 0; p < 50; p++) send_packet(188, 2, 1);
    drain();

    // abort at byte 100
    eop_before = eop_cnt;
    send_packet(100, 2, 0);
    send_packet(188, 2, 0);
    drain();
    check("abort_eops", eop_cnt - eop_before, 1);

    // reset mid-parity after p_5
    eop_before = eop_cnt;
    send_packet(188, 2, 0);
    idle(1);
    begin
      int w = 0;
      while (cw_idx < 194 && w < 100) begin
        @(negedge Clk);
        #1;
        w++;
      end
      check("reach_p5", cw_idx, 194);
    end
    #1;
    Reset = 1'b0;
    #1;
    check("async_rst_valid", Out_Valid, 0);
    check("async_rst_data", Out_Data, 0);
    check("async_rst_eop", Out_Eop, 0);
    check("async_rst_ready", In_Ready, 1);
    exp_q.delete();
    m_in_pkt = 0;
    cw_idx   = 0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    check("reset_no_eop", eop_cnt - eop_before, 0);
    send_packet(188, 1, 0);
    drain();
    check("post_reset_p15", cw[203], gpow(120));
    send_packet(188, 2, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
